data_bus_responder: RTL
=======================

Name: data_bus_responder

Overview:
- Responder end of the processor's data-memory port: consumes memory_addr / memory_write_enable / memory_in and returns registered read data one cycle later.
- Decodes the 18-bit address space into on-chip data RAM, an unmapped hole, and a 16-word memory-mapped I/O window at the top of the space.
- The I/O window holds an LED register, a transmit FIFO with a valid/ready output handshake, a countdown timer, and sticky status bits.
- Generates the wake pulse that releases the processor from its WAIT state.

Parameters:
ADDR_SIZE, 18, address width
WORD_SIZE, 18, data width
RAM_ADDR_BITS, 12, RAM holds 2^RAM_ADDR_BITS words at addresses 0..2^RAM_ADDR_BITS-1
TX_DEPTH_LOG2, 2, TX FIFO depth = 2^TX_DEPTH_LOG2 (4)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
memory_addr  in  ADDR_SIZE  word address from processor
memory_write_enable  in  1  write strobe
memory_in  in  WORD_SIZE  write data
memory_out  out  WORD_SIZE  read data, valid the cycle after the address
waiting  in  1  processor is stalled in WAIT
wake  out  1  one-cycle pulse releasing WAIT
ext_event  in  1  external wake source, level
leds  out  WORD_SIZE  LED register
tx_valid  out  1  FIFO non-empty
tx_data  out  WORD_SIZE  FIFO head
tx_ready  in  1  consumer accepts head

Behaviour:
- Reset: memory_out=0, leds=0, wake=0, FIFO empty (tx_valid=0, tx_data=0), timer reload=0, timer count=0, status=0. RAM contents are not reset.
- Reset mid-operation discards FIFO contents and any pending wake.
- Read latency is exactly 1 cycle: memory_out <= decode(memory_addr) at every posedge, whether or not a write is present.
- RAM read-during-write to the same address returns the OLD data (read-first).
- Address regions:
  - RAM: addresses 0..2^RAM_ADDR_BITS-1.
  - IO window: IO_BASE = 2^ADDR_SIZE-16 (0x3FFF0).
  - Hole: addresses between RAM and IO read 0; writes are ignored.
- IO registers (offset from IO_BASE):
  - +0 LEDS, RW.
  - +1 TX: a write pushes memory_in; a read returns the FIFO level, zero-extended.
  - +2 TIMER_RELOAD, RW.
  - +3 TIMER_COUNT: reads return the current count; any write loads count<=reload.
  - +4 STATUS, R/W1C: bit0 fifo_full, bit1 fifo_empty (both live), bit2 timer_expired (sticky), bit3 ext_event_seen (sticky), bit4 tx_overflow (sticky). Writing 1 clears the corresponding sticky bit.
  - +5..+15: read 0, writes ignored.
- TX FIFO:
  - Circular buffer with TX_DEPTH_LOG2+1-bit pointers. Wrap-around is natural; full when the pointers differ only in their MSB.
  - tx_valid = !empty; tx_data = head entry, or 0 when empty.
  - Pop when tx_valid && tx_ready.
  - Push when full and no pop in the same cycle: data dropped, tx_overflow set.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push into an empty FIFO: tx_valid rises the next cycle.
- Timer:
  - reload==0: count is held at 0 (stopped).
  - Otherwise each cycle: if count==0 or count==1, count<=reload; else count<=count-1.
  - count==1 also produces an internal one-cycle expire event and sets timer_expired.
  - Resulting period is reload cycles.
  - A write to TIMER_COUNT in the same cycle as an expiry wins (count<=reload); the expire event still fires.
- Sticky-bit priority: setting takes precedence over a W1C clear in the same cycle.
- ext_event_seen sets on any cycle with ext_event=1.
- wake is registered: wake <= waiting && (expire || ext_event). It is therefore at most one cycle wide per event, and 0 while waiting=0 (events while not waiting only set sticky bits).

Optional Feature:
DATA_BUS_RESPONDER_TIMER_EN
- Defined: timer as described.
- Undefined:
  - No timer logic is generated.
  - TIMER_RELOAD and TIMER_COUNT read 0 and ignore writes.
  - STATUS bit2 reads 0.
  - wake derives from ext_event only.

Test Plan:
- RAM: write 0x12345 @0x010, then read 0x010 -> memory_out=0x12345 one cycle after the read address. A same-cycle read+write of 0x2AAAA to 0x010 returns 0x12345.
- Hole/IO: read 0x20000 -> 0; write LEDS (0x3FFF0)=0x3F -> leds=0x3F next cycle, readback 0x3F. Read offset +9 -> 0.
- FIFO: with tx_ready=0, push 5 words (1..5) -> level reads 4, STATUS=0x11 (full+overflow). Then tx_ready=1 -> tx_data 1,2,3,4 on consecutive cycles, then tx_valid=0 and STATUS bit1=1.
- FIFO full with simultaneous push 9 and pop -> no overflow, level stays 4, 9 emerges last.
- Timer: reload=5, write TIMER_COUNT -> timer_expired sets every 5 cycles. With waiting=1, wake pulses exactly 1 cycle after each expiry; W1C 0x04 clears bit2.
- ext_event held 3 cycles with waiting=0 -> wake stays 0, STATUS bit3=1. Assert reset while FIFO holds 2 words -> tx_valid=0, level 0.

Source files
------------

// File: rtl/data_bus_responder_if.sv
// Data-memory port between the processor and the responder, bundled with the
// WAIT/wake pair and the transmit FIFO output handshake.
// master: processor/consumer side, slave: data_bus_responder.
interface data_bus_responder_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic [ADDR_SIZE-1:0] memory_addr;
  logic                 memory_write_enable;
  logic [WORD_SIZE-1:0] memory_in;
  logic [WORD_SIZE-1:0] memory_out;
  logic                 waiting;
  logic                 wake;
  logic                 tx_valid;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 tx_ready;

  modport master (
    output memory_addr, memory_write_enable, memory_in, waiting, tx_ready,
    input  memory_out, wake, tx_valid, tx_data
  );

  modport slave (
    input  memory_addr, memory_write_enable, memory_in, waiting, tx_ready,
    output memory_out, wake, tx_valid, tx_data
  );
endinterface

// File: rtl/data_bus_responder.sv
// Responder end of the processor data-memory port: on-chip RAM, an unmapped
// hole and a 16-word I/O window (LEDs, TX FIFO, timer, sticky status).
// Read data is registered, one cycle after the address.
// Optional countdown timer enabled by defining DATA_BUS_RESPONDER_TIMER_EN;
// without it TIMER_RELOAD/TIMER_COUNT read 0 and wake comes from ext_event only.
module data_bus_responder #(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int RAM_ADDR_BITS = 12,
  parameter int TX_DEPTH_LOG2 = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  input  logic                 ext_event,
  output logic [WORD_SIZE-1:0] leds
);
  localparam int PTR_W = TX_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << TX_DEPTH_LOG2;

  // Address decode; the I/O window is the top 16 words of the space.
  logic       in_ram, in_io;
  logic [3:0] io_off;
  logic       wr_leds, wr_tx, wr_reload, wr_count, wr_status;

  assign in_ram    = (bus.memory_addr[ADDR_SIZE-1:RAM_ADDR_BITS] == '0);
  assign in_io     = &bus.memory_addr[ADDR_SIZE-1:4];
  assign io_off    = bus.memory_addr[3:0];
  assign wr_leds   = bus.memory_write_enable && in_io && (io_off == 4'd0);
  assign wr_tx     = bus.memory_write_enable && in_io && (io_off == 4'd1);
  assign wr_reload = bus.memory_write_enable && in_io && (io_off == 4'd2);
  assign wr_count  = bus.memory_write_enable && in_io && (io_off == 4'd3);
  assign wr_status = bus.memory_write_enable && in_io && (io_off == 4'd4);

  // TX FIFO: extra pointer MSB distinguishes full from empty.
  logic [WORD_SIZE-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, level;
  logic                 empty, full, pop, push, overflow;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {TX_DEPTH_LOG2{1'b0}}});
  assign pop      = !empty && bus.tx_ready;
  assign push     = wr_tx && (!full || pop);
  assign overflow = wr_tx && full && !pop;

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? '0 : fifo_mem[rd_ptr[TX_DEPTH_LOG2-1:0]];

  // FIFO pointers advance on accepted push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage holds data only, so it is not reset.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[TX_DEPTH_LOG2-1:0]] <= bus.memory_in;
  end

  logic                 expire;
  logic                 timer_expired;
  logic [WORD_SIZE-1:0] reload_rd, count_rd;

`ifdef DATA_BUS_RESPONDER_TIMER_EN
  logic [WORD_SIZE-1:0] reload, count;

  assign expire    = (reload != '0) && (count == WORD_SIZE'(1));
  assign reload_rd = reload;
  assign count_rd  = count;

  // Countdown with period 'reload'; a TIMER_COUNT write restarts it and wins over the wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      reload <= '0;
      count  <= '0;
    end else begin
      if (wr_reload) reload <= bus.memory_in;
      if (wr_count)                      count <= reload;
      else if (reload == '0)             count <= '0;
      else if (count <= WORD_SIZE'(1))   count <= reload;
      else                               count <= count - WORD_SIZE'(1);
    end
  end

  // Sticky expiry flag; a new expiry beats a simultaneous W1C.
  always_ff @(posedge clock) begin
    if (reset) timer_expired <= 1'b0;
    else       timer_expired <= expire || (timer_expired && !(wr_status && bus.memory_in[2]));
  end
`else
  assign expire        = 1'b0;
  assign timer_expired = 1'b0;
  assign reload_rd     = '0;
  assign count_rd      = '0;
`endif

  logic ext_seen, tx_overflow;

  // Sticky event flags; setting has priority over a W1C clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      ext_seen    <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      ext_seen    <= ext_event || (ext_seen && !(wr_status && bus.memory_in[3]));
      tx_overflow <= overflow  || (tx_overflow && !(wr_status && bus.memory_in[4]));
    end
  end

  logic [WORD_SIZE-1:0] status_word, io_rd;
  assign status_word = WORD_SIZE'({tx_overflow, ext_seen, timer_expired, empty, full});

  // I/O window read mux; the hole and unused offsets return 0.
  always_comb begin
    io_rd = '0;
    if (in_io) begin
      case (io_off)
        4'd0:    io_rd = leds;
        4'd1:    io_rd = WORD_SIZE'(level);
        4'd2:    io_rd = reload_rd;
        4'd3:    io_rd = count_rd;
        4'd4:    io_rd = status_word;
        default: io_rd = '0;
      endcase
    end
  end

  // Data RAM, read-first: the registered read sees the pre-write contents.
  logic [WORD_SIZE-1:0] ram [2**RAM_ADDR_BITS];
  logic [WORD_SIZE-1:0] ram_rd_p1;

  always_ff @(posedge clock) begin
    if (bus.memory_write_enable && in_ram)
      ram[bus.memory_addr[RAM_ADDR_BITS-1:0]] <= bus.memory_in;
    ram_rd_p1 <= ram[bus.memory_addr[RAM_ADDR_BITS-1:0]];
  end

  // ---- stage p1: registered read select, LED register and wake pulse ----
  logic                 sel_ram_p1;
  logic [WORD_SIZE-1:0] io_rd_p1;
  logic                 wake_p1;

  // Control/output registers that must come up cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_ram_p1 <= 1'b0;
      io_rd_p1   <= '0;
      leds       <= '0;
      wake_p1    <= 1'b0;
    end else begin
      sel_ram_p1 <= in_ram;
      io_rd_p1   <= io_rd;
      if (wr_leds) leds <= bus.memory_in;
      wake_p1    <= bus.waiting && (expire || ext_event);
    end
  end

  assign bus.memory_out = sel_ram_p1 ? ram_rd_p1 : io_rd_p1;
  assign bus.wake       = wake_p1;
endmodule
